// File: rtl/pipe_control_unit.sv
// pipe_control_unit: opcode decode, hazard control and ID/EX, EX/MEM, MEM/WB control registers.
//   clk, reset                 : clock, synchronous active-high reset
//   in_OP_6, in_Rs_5, in_Rt_5  : opcode, rs, rt of the instruction in IF/ID
//   in_BranchTaken             : EX-stage branch resolved taken
//   o_PCWrite, o_IFIDWrite     : PC and IF/ID write enables
//   o_IFIDFlush, o_ID_Jump     : IF/ID flush and jump redirect
//   o_EX_*                     : ID/EX control fields
//   o_MEM_*                    : EX/MEM control fields
//   o_WB_*                     : MEM/WB control fields
module pipe_control_unit #(
    parameter int ALUOP_W   = 3,
    parameter bit LU_DETECT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         in_OP_6,
    input  logic [4:0]         in_Rs_5,
    input  logic [4:0]         in_Rt_5,
    input  logic               in_BranchTaken,
    output logic               o_PCWrite,
    output logic               o_IFIDWrite,
    output logic               o_IFIDFlush,
    output logic               o_ID_Jump,
    output logic               o_EX_RegDst,
    output logic               o_EX_ALUSrc,
    output logic [ALUOP_W-1:0] o_EX_ALUOp,
    output logic               o_EX_BranchEn,
    output logic               o_EX_BranchType,
    output logic               o_MEM_MemRead,
    output logic               o_MEM_MemWrite,
    output logic               o_WB_MemtoReg,
    output logic               o_WB_RegWrite,
    output logic               o_WB_Link
);
    logic       d_jump, d_regdst, d_alusrc, d_memtoreg, d_regwrite;
    logic       d_memread, d_memwrite, d_branch_en, d_branch_type, d_link;
    logic [2:0] d_aluop;
    logic       ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_link;
    logic [4:0] ex_rt;
    logic       mem_memtoreg, mem_regwrite, mem_link;
    logic       load_use, bubble;

    always_comb begin
        d_jump        = 1'b0;
        d_regdst      = 1'b0;
        d_alusrc      = 1'b0;
        d_memtoreg    = 1'b0;
        d_regwrite    = 1'b0;
        d_memread     = 1'b0;
        d_memwrite    = 1'b0;
        d_branch_en   = 1'b0;
        d_branch_type = 1'b0;
        d_link        = 1'b0;
        d_aluop       = 3'd0;
        case (in_OP_6)
            6'h00: begin d_regdst = 1'b1; d_regwrite = 1'b1; d_aluop = 3'd7; end
            6'h08: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 3'd4; end
            6'h0D: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 3'd5; end
            6'h0C: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 3'd6; end
            6'h0F: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 3'd0; end
            6'h23: begin
                d_alusrc = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1;
                d_memread = 1'b1; d_aluop = 3'd3;
            end
            6'h2B: begin d_alusrc = 1'b1; d_memwrite = 1'b1; d_aluop = 3'd3; end
            6'h04: begin d_branch_en = 1'b1; d_branch_type = 1'b1; d_aluop = 3'd1; end
            6'h05: begin d_branch_en = 1'b1; d_aluop = 3'd1; end
            6'h02: begin d_jump = 1'b1; d_aluop = 3'd2; end
            6'h03: begin d_jump = 1'b1; d_regwrite = 1'b1; d_link = 1'b1; d_aluop = 3'd2; end
            default: ;
        endcase
    end

    // A bubble in ID/EX clears MemRead, so a load-use stall can never last beyond one cycle.
    assign load_use    = LU_DETECT && ex_memread && ex_rt != 5'd0 && (ex_rt == in_Rs_5 || ex_rt == in_Rt_5);
    assign bubble      = in_BranchTaken || load_use;
    assign o_PCWrite   = in_BranchTaken || !load_use;
    assign o_IFIDWrite = in_BranchTaken || !load_use;
    assign o_ID_Jump   = d_jump && !bubble;
    assign o_IFIDFlush = in_BranchTaken || (d_jump && !load_use);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            o_EX_RegDst     <= 1'b0;
            o_EX_ALUSrc     <= 1'b0;
            o_EX_ALUOp      <= '0;
            o_EX_BranchEn   <= 1'b0;
            o_EX_BranchType <= 1'b0;
            ex_memtoreg     <= 1'b0;
            ex_regwrite     <= 1'b0;
            ex_memread      <= 1'b0;
            ex_memwrite     <= 1'b0;
            ex_link         <= 1'b0;
            ex_rt           <= 5'd0;
        end else begin
            o_EX_RegDst     <= d_regdst;
            o_EX_ALUSrc     <= d_alusrc;
            o_EX_ALUOp      <= ALUOP_W'(d_aluop);
            o_EX_BranchEn   <= d_branch_en;
            o_EX_BranchType <= d_branch_type;
            ex_memtoreg     <= d_memtoreg;
            ex_regwrite     <= d_regwrite;
            ex_memread      <= d_memread;
            ex_memwrite     <= d_memwrite;
            ex_link         <= d_link;
            ex_rt           <= in_Rt_5;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_MEM_MemRead  <= 1'b0;
            o_MEM_MemWrite <= 1'b0;
            mem_memtoreg   <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_link       <= 1'b0;
            o_WB_MemtoReg  <= 1'b0;
            o_WB_RegWrite  <= 1'b0;
            o_WB_Link      <= 1'b0;
        end else begin
            o_MEM_MemRead  <= ex_memread;
            o_MEM_MemWrite <= ex_memwrite;
            mem_memtoreg   <= ex_memtoreg;
            mem_regwrite   <= ex_regwrite;
            mem_link       <= ex_link;
            o_WB_MemtoReg  <= mem_memtoreg;
            o_WB_RegWrite  <= mem_regwrite;
            o_WB_Link      <= mem_link;
        end
    end
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed vector bench for pipe_control_unit.
module tb_pipe_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       br;
    logic       pc_write, ifid_write, ifid_flush, id_jump;
    logic       ex_regdst, ex_alusrc, ex_ben, ex_btype;
    logic [2:0] ex_aluop;
    logic       mem_rd, mem_wr, wb_m2r, wb_rw, wb_link;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic [3:0] ctl;
        logic [6:0] ex;
        logic [1:0] mem;
        logic [2:0] wb;
    } vec_t;
    vec_t vecs[$];

    pipe_control_unit dut (
        .clk(clk), .reset(reset), .in_OP_6(op), .in_Rs_5(rs), .in_Rt_5(rt),
        .in_BranchTaken(br), .o_PCWrite(pc_write), .o_IFIDWrite(ifid_write),
        .o_IFIDFlush(ifid_flush), .o_ID_Jump(id_jump), .o_EX_RegDst(ex_regdst),
        .o_EX_ALUSrc(ex_alusrc), .o_EX_ALUOp(ex_aluop), .o_EX_BranchEn(ex_ben),
        .o_EX_BranchType(ex_btype), .o_MEM_MemRead(mem_rd), .o_MEM_MemWrite(mem_wr),
        .o_WB_MemtoReg(wb_m2r), .o_WB_RegWrite(wb_rw), .o_WB_Link(wb_link)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s vec %0d: got %b expected %b", name, idx, got, exp);
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic b, input logic [3:0] c, input logic [6:0] e, input logic [1:0] m,
                       input logic [2:0] w);
        vecs.push_back('{r, o, s, t, b, c, e, m, w});
    endtask

    initial begin
        // ctl = {PCWrite, IFIDWrite, IFIDFlush, ID_Jump}
        // ex  = {RegDst, ALUSrc, ALUOp[2:0], BranchEn, BranchType}; mem = {MemRead, MemWrite}; wb = {MemtoReg, RegWrite, Link}
        add(0, 6'h08, 1, 2, 0, 4'b1100, 7'b0110000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b010);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h23, 1, 5, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(0, 6'h00, 5, 6, 0, 4'b0000, 7'b0000000, 2'b10, 3'b000);
        add(0, 6'h00, 5, 6, 0, 4'b1100, 7'b1011100, 2'b00, 3'b110);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b010);
        add(0, 6'h23, 1, 0, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(0, 6'h00, 0, 0, 0, 4'b1100, 7'b1011100, 2'b10, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b110);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b010);
        add(0, 6'h23, 1, 7, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(0, 6'h00, 7, 3, 1, 4'b1110, 7'b0000000, 2'b10, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b110);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h03, 0, 0, 0, 4'b1111, 7'b0001000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b011);
        add(0, 6'h04, 1, 2, 0, 4'b1100, 7'b0000111, 2'b00, 3'b000);
        add(0, 6'h05, 1, 2, 0, 4'b1100, 7'b0000110, 2'b00, 3'b000);
        add(0, 6'h2B, 1, 2, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(0, 6'h0D, 1, 2, 0, 4'b1100, 7'b0110100, 2'b01, 3'b000);
        add(0, 6'h0C, 1, 2, 0, 4'b1100, 7'b0111000, 2'b00, 3'b000);
        add(0, 6'h0F, 1, 2, 0, 4'b1100, 7'b0100000, 2'b00, 3'b010);
        add(0, 6'h02, 0, 0, 0, 4'b1111, 7'b0001000, 2'b00, 3'b010);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b010);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h23, 0, 4, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(0, 6'h02, 4, 0, 0, 4'b0000, 7'b0000000, 2'b10, 3'b000);
        add(0, 6'h02, 4, 0, 0, 4'b1111, 7'b0001000, 2'b00, 3'b110);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h23, 0, 5, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(1, 6'h3F, 5, 0, 0, 4'b0000, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 5, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h08, 0, 0, 0, 4'b1100, 7'b0110000, 2'b00, 3'b000);
        add(1, 6'h08, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h3F, 0, 0, 0, 4'b1100, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h23, 0, 6, 0, 4'b1100, 7'b0101100, 2'b00, 3'b000);
        add(1, 6'h00, 6, 0, 1, 4'b1110, 7'b0000000, 2'b00, 3'b000);
        add(0, 6'h00, 6, 0, 0, 4'b1100, 7'b1011100, 2'b00, 3'b000);

        reset = 1'b1; op = 6'h3F; rs = '0; rt = '0; br = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", -1, {1'b0, ex_regdst, ex_alusrc, ex_aluop, ex_ben, ex_btype,
              mem_rd, mem_wr, wb_m2r, wb_rw, wb_link} >> 0 != 0 ? 8'hFF : 8'h00, 8'h00);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; rs = vecs[i].rs; rt = vecs[i].rt; br = vecs[i].br;
            #1;
            check("ctl", i, {4'b0, pc_write, ifid_write, ifid_flush, id_jump}, {4'b0, vecs[i].ctl});
            @(posedge clk);
            #1;
            check("ex", i, {1'b0, ex_regdst, ex_alusrc, ex_aluop, ex_ben, ex_btype}, {1'b0, vecs[i].ex});
            check("mem", i, {6'b0, mem_rd, mem_wr}, {6'b0, vecs[i].mem});
            check("wb", i, {5'b0, wb_m2r, wb_rw, wb_link}, {5'b0, vecs[i].wb});
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
